// File: rtl/sim_cache_top.sv
// Unified direct-mapped write-through / no-write-allocate cache (256 lines x 16 B)
// shared by an instruction port and a data port, backed by a single-word memory bus.
module sim_cache_top (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] inst_address,
    input  logic        inst_read,
    output logic [31:0] inst_readdata,
    output logic        inst_waitrequest,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP} state_t;
    state_t r_state, w_state_next;

    logic [19:0]  r_tag_ram  [0:255];
    logic [31:0]  r_data_ram [0:1023];
    logic [255:0] r_valid;

    logic        r_rr_data;    // 1: data port wins the next contended grant
    logic        r_port_data;
    logic        r_is_write;
    logic [29:0] r_addr;       // word address of the request in service
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_hit;
    logic [1:0]  r_fill_cnt;
    logic [31:0] r_fill_word;
    logic [19:0] r_tag_q;
    logic [31:0] r_word_q;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_inst_req, w_data_req, w_grant, w_grant_data, w_hit, w_mem_ack;
    logic [31:0] w_req_addr, w_merged, w_ram_wdata, w_resp_val;
    logic [19:0] w_tag;
    logic [7:0]  w_idx;
    logic [1:0]  w_word;
    logic [9:0]  w_ram_waddr;
    logic        w_ram_we, w_tag_we, w_resp_load;
    logic        w_unused_addr_lsbs;

    assign w_inst_req   = inst_read;
    assign w_data_req   = data_read | data_write;
    assign w_grant      = (r_state == S_IDLE) && (w_inst_req || w_data_req);
    assign w_grant_data = w_data_req && (!w_inst_req || r_rr_data);
    assign w_req_addr   = w_grant_data ? data_address : inst_address;
    assign w_unused_addr_lsbs = ^{inst_address[1:0], data_address[1:0]};

    assign w_tag     = r_addr[29:10];
    assign w_idx     = r_addr[9:2];
    assign w_word    = r_addr[1:0];
    assign w_hit     = r_valid[w_idx] && (r_tag_q == w_tag);
    assign w_mem_ack = !mem_waitrequest;

    // Byte-lane merge of the write data into the previously cached word
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : r_word_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        mem_address    = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'd0;
        mem_byteenable = 4'd0;
        w_ram_we       = 1'b0;
        w_ram_waddr    = {w_idx, r_fill_cnt};
        w_ram_wdata    = mem_readdata;
        w_tag_we       = 1'b0;
        case (r_state)
            S_IDLE:   if (w_grant) w_state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (r_is_write)  w_state_next = S_WRITE;
                else if (w_hit)  w_state_next = S_RESP;
                else             w_state_next = S_FILL;
            end
            S_FILL: begin
                mem_read    = 1'b1;
                mem_address = {w_tag, w_idx, r_fill_cnt, 2'b00};
                if (w_mem_ack) begin
                    w_ram_we = 1'b1;
                    if (r_fill_cnt == 2'd3) begin
                        w_tag_we     = 1'b1;
                        w_state_next = S_RESP;
                    end
                end
            end
            S_WRITE: begin
                mem_write      = 1'b1;
                mem_address    = {r_addr, 2'b00};
                mem_writedata  = r_wdata;
                mem_byteenable = r_be;
                if (w_mem_ack) begin
                    w_ram_we     = r_hit;
                    w_ram_waddr  = {w_idx, w_word};
                    w_ram_wdata  = w_merged;
                    w_state_next = S_RESP;
                end
            end
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        // Bus is forced quiet while reset is held, even mid-transaction
        if (reset_reset) begin
            mem_address    = 32'd0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_writedata  = 32'd0;
            mem_byteenable = 4'd0;
        end
    end

    // Response word is latched only on entry to RESP so readdata stays stable otherwise
    assign w_resp_load = ((r_state == S_LOOKUP) && !r_is_write && w_hit) ||
                         ((r_state == S_FILL) && w_mem_ack && (r_fill_cnt == 2'd3));
    assign w_resp_val  = (r_state == S_LOOKUP) ? r_word_q :
                         ((w_word == 2'd3) ? mem_readdata : r_fill_word);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_rr_data    <= 1'b1;
            r_port_data  <= 1'b0;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_hit        <= 1'b0;
            r_fill_cnt   <= '0;
            r_fill_word  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_port_data <= w_grant_data;
                r_is_write  <= w_grant_data && data_write;
                r_addr      <= w_req_addr[31:2];
                r_wdata     <= data_writedata;
                r_be        <= data_byteenable;
                if (w_inst_req && w_data_req) r_rr_data <= !w_grant_data;
            end
            if (r_state == S_LOOKUP) begin
                r_hit      <= w_hit;
                r_fill_cnt <= 2'd0;
                // The line is overwritten word by word, so it must not look valid meanwhile
                if (!r_is_write && !w_hit) r_valid[w_idx] <= 1'b0;
            end
            if ((r_state == S_FILL) && w_mem_ack) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
                if (r_fill_cnt == w_word)  r_fill_word    <= mem_readdata;
                if (r_fill_cnt == 2'd3)    r_valid[w_idx] <= 1'b1;
            end
            if (w_resp_load) begin
                if (r_port_data) r_data_rdata <= w_resp_val;
                else             r_inst_rdata <= w_resp_val;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_grant) begin
            r_tag_q  <= r_tag_ram[w_req_addr[11:4]];
            r_word_q <= r_data_ram[w_req_addr[11:2]];
        end
        if (w_tag_we) r_tag_ram[w_idx] <= w_tag;
        if (w_ram_we) r_data_ram[w_ram_waddr] <= w_ram_wdata;
    end

    assign inst_readdata    = r_inst_rdata;
    assign data_readdata    = r_data_rdata;
    assign inst_waitrequest = reset_reset || !((r_state == S_RESP) && !r_port_data);
    assign data_waitrequest = reset_reset || !((r_state == S_RESP) && r_port_data);
endmodule

// File: tb/tb_sim_cache_top.sv
// Directed vector table plus hand sequences and a randomized two-port stress run
// for the unified cache, with a word-addressed memory model behind the bus.
module tb_sim_cache_top;
    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] inst_address = '0;
    logic        inst_read = 1'b0;
    logic [31:0] inst_readdata;
    logic        inst_waitrequest;
    logic [31:0] data_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [3:0]  data_byteenable = '0;
    logic [31:0] data_readdata;
    logic        data_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest = 1'b0;

    sim_cache_top dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inst_address(inst_address), .inst_read(inst_read),
        .inst_readdata(inst_readdata), .inst_waitrequest(inst_waitrequest),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_byteenable(data_byteenable),
        .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    int cyc_now = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit rand_wait_en = 1'b0;
    logic [31:0] rd_addrs[$];
    logic [31:0] last_wa, last_wd;
    logic [3:0]  last_be;
    logic [31:0] mem_arr [0:4095];
    logic [31:0] ref_mem [0:4095];

    assign mem_readdata = mem_arr[mem_address[13:2]];

    always @(posedge clk_clk) cyc_now++;

    always begin
        @(posedge clk_clk);
        #1;
        mem_waitrequest = rand_wait_en && ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk_clk) begin
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL mem_rd_wr_overlap actual=both_high required=exclusive");
        end
        if (mem_read && !mem_waitrequest) begin
            rd_cnt++;
            rd_addrs.push_back(mem_address);
        end
        if (mem_write && !mem_waitrequest) begin
            wr_cnt++;
            last_wa = mem_address; last_wd = mem_writedata; last_be = mem_byteenable;
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) mem_arr[mem_address[13:2]][8*b +: 8] = mem_writedata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic inst_xfer(input logic [31:0] a, output logic [31:0] d, output int cyc);
        inst_address = a; inst_read = 1'b1; cyc = 0;
        do begin
            @(negedge clk_clk); cyc++;
        end while (inst_waitrequest && cyc < 300);
        if (inst_waitrequest) begin
            checks++; errors++;
            $display("FAIL inst_timeout addr=%h actual=stalled required=response", a);
        end
        d = inst_readdata;
        @(posedge clk_clk); #1;
        inst_read = 1'b0;
    endtask

    task automatic data_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] d, output int cyc);
        data_address = a; data_read = !wr; data_write = wr;
        data_writedata = wd; data_byteenable = be; cyc = 0;
        do begin
            @(negedge clk_clk); cyc++;
        end while (data_waitrequest && cyc < 300);
        if (data_waitrequest) begin
            checks++; errors++;
            $display("FAIL data_timeout addr=%h actual=stalled required=response", a);
        end
        d = data_readdata;
        @(posedge clk_clk); #1;
        data_read = 1'b0; data_write = 1'b0;
    endtask

    typedef struct {
        bit          is_inst;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        int          exp_rd;
        int          exp_wr;
        int          exp_cyc;
    } vec_t;
    vec_t vecs[12];

    logic [31:0] d_i, d_d, exp_i, exp_d;
    int c_i, c_d;

    initial begin
        for (int i = 0; i < 4096; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
        mem_arr[32'h40 >> 2]   = 32'h40404040; mem_arr[32'h1040 >> 2] = 32'h10401040;
        mem_arr[32'h200 >> 2]  = 32'hA5A50200; mem_arr[32'h300 >> 2]  = 32'h5A5A0300;
        mem_arr[32'h500 >> 2]  = 32'h55550500;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem_arr[i];

        //          inst wr  addr          wdata         be     exp_data      rd wr cyc
        vecs[0]  = '{1'b0, 1'b0, 32'h100,  32'h0,        4'hF, 32'h00000000, 4, 0, 7};
        vecs[1]  = '{1'b0, 1'b0, 32'h100,  32'h0,        4'hF, 32'h00000000, 0, 0, 3};
        vecs[2]  = '{1'b0, 1'b1, 32'h104,  32'hDEADBEEF, 4'hF, 32'h0,        0, 1, 4};
        vecs[3]  = '{1'b1, 1'b0, 32'h104,  32'h0,        4'hF, 32'hDEADBEEF, 0, 0, 3};
        vecs[4]  = '{1'b0, 1'b1, 32'h2000, 32'h11223344, 4'h3, 32'h0,        0, 1, 4};
        vecs[5]  = '{1'b0, 1'b0, 32'h2000, 32'h0,        4'hF, 32'h00003344, 4, 0, 7};
        vecs[6]  = '{1'b0, 1'b0, 32'h40,   32'h0,        4'hF, 32'h40404040, 4, 0, 7};
        vecs[7]  = '{1'b0, 1'b0, 32'h1040, 32'h0,        4'hF, 32'h10401040, 4, 0, 7};
        vecs[8]  = '{1'b0, 1'b0, 32'h40,   32'h0,        4'hF, 32'h40404040, 4, 0, 7};
        vecs[9]  = '{1'b1, 1'b0, 32'h107,  32'h0,        4'hF, 32'hDEADBEEF, 0, 0, 3};
        vecs[10] = '{1'b0, 1'b1, 32'h104,  32'h00AA0000, 4'h4, 32'h0,        0, 1, 4};
        vecs[11] = '{1'b1, 1'b0, 32'h104,  32'h0,        4'hF, 32'hDEAABEEF, 0, 0, 3};

        // Reset state
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        chk("rst_waitreq", {30'd0, inst_waitrequest, data_waitrequest}, 32'd3);
        chk("rst_mem_ctl", {28'd0, mem_read, mem_write, 2'd0}, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_wd_be", mem_writedata | {28'd0, mem_byteenable}, 32'd0);
        chk("rst_rdata", inst_readdata | data_readdata, 32'd0);
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;

        // Simultaneous requests in the first cycle after reset: data first, then inst
        rd_cnt = 0;
        fork
            inst_xfer(32'h200, d_i, c_i);
            data_xfer(1'b0, 32'h300, 32'h0, 4'hF, d_d, c_d);
        join
        chk("arb_data_val", d_d, 32'h5A5A0300);
        chk("arb_inst_val", d_i, 32'hA5A50200);
        chk("arb_data_cyc", c_d, 7);
        chk("arb_inst_cyc", c_i, 14);
        chk("arb_mem_reads", rd_cnt, 8);
        $display("txn arb: data=%h (%0d cyc) inst=%h (%0d cyc)", d_d, c_d, d_i, c_i);

        foreach (vecs[v]) begin
            rd_cnt = 0; wr_cnt = 0; rd_addrs.delete();
            if (vecs[v].is_inst) inst_xfer(vecs[v].addr, d_i, c_i);
            else data_xfer(vecs[v].is_write, vecs[v].addr, vecs[v].wdata, vecs[v].be, d_i, c_i);
            $display("txn vec%0d: %s %s addr=%h data=%h cyc=%0d rd=%0d wr=%0d", v,
                     vecs[v].is_inst ? "inst" : "data", vecs[v].is_write ? "wr" : "rd",
                     vecs[v].addr, d_i, c_i, rd_cnt, wr_cnt);
            chk($sformatf("vec%0d_cyc", v), c_i, vecs[v].exp_cyc);
            chk($sformatf("vec%0d_rd", v), rd_cnt, vecs[v].exp_rd);
            chk($sformatf("vec%0d_wr", v), wr_cnt, vecs[v].exp_wr);
            if (vecs[v].is_write) begin
                ref_mem[vecs[v].addr[13:2]] = merge(ref_mem[vecs[v].addr[13:2]],
                                                    vecs[v].wdata, vecs[v].be);
                chk($sformatf("vec%0d_waddr", v), last_wa, {vecs[v].addr[31:2], 2'b00});
                chk($sformatf("vec%0d_wdata", v), last_wd, vecs[v].wdata);
                chk($sformatf("vec%0d_wbe", v), {28'd0, last_be}, {28'd0, vecs[v].be});
            end else begin
                chk($sformatf("vec%0d_data", v), d_i, vecs[v].exp_data);
                if (vecs[v].exp_rd == 4 && rd_addrs.size() == 4)
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("vec%0d_fill%0d", v, k), rd_addrs[k],
                            {vecs[v].addr[31:4], k[1:0], 2'b00});
            end
        end

        // Reset in the middle of a fill: bus drops, line stays invalid, request reissued
        data_address = 32'h500; data_read = 1'b1;
        repeat (4) @(negedge clk_clk);
        reset_reset = 1'b1; data_read = 1'b0;
        #1;
        chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("midrst_waitreq", {31'd0, data_waitrequest}, 32'd1);
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        rd_cnt = 0;
        data_xfer(1'b0, 32'h500, 32'h0, 4'hF, d_d, c_d);
        chk("midrst_refill_val", d_d, 32'h55550500);
        chk("midrst_refill_rd", rd_cnt, 4);
        rd_cnt = 0;
        data_xfer(1'b0, 32'h104, 32'h0, 4'hF, d_d, c_d);
        chk("postrst_miss_val", d_d, 32'hDEAABEEF);
        chk("postrst_miss_rd", rd_cnt, 4);
        $display("txn midrst: reread 0x500=%h 0x104=%h", 32'h55550500, d_d);

        // Randomized concurrent traffic with random memory stalls
        rand_wait_en = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            int ia, da, lim;
            bit wr;
            logic [31:0] wd;
            lim = ($urandom_range(0, 1) == 1) ? 255 : 2047;
            ia = $urandom_range(0, lim);
            do da = $urandom_range(0, lim); while (da == ia);
            wr = $urandom_range(0, 1);
            wd = $urandom;
            exp_i = ref_mem[ia];
            exp_d = ref_mem[da];
            fork
                inst_xfer(ia * 4, d_i, c_i);
                data_xfer(wr, da * 4, wd, 4'hF, d_d, c_d);
            join
            chk($sformatf("stress%0d_inst", it), d_i, exp_i);
            if (wr) ref_mem[da] = wd;
            else chk($sformatf("stress%0d_data", it), d_d, exp_d);
            if (it % 100 == 0)
                $display("txn stress%0d: inst %h=%h data %s %h", it, ia * 4, d_i,
                         wr ? "wr" : "rd", da * 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
